adder6: RTL and testbench

- Registered 4-bit carry-lookahead adder: F = A + B + C0, carry-out on C4.
- Standalone arithmetic leaf used by datapath/lab top levels.
- Operands and carry-in are sampled on each rising clock edge; sum and carry are presented from output registers one cycle later.
- Width is parameterised in 4-bit lookahead groups; the default build is the 4-bit instance.

---
 rtl/adder_pkg.sv | 10 +
 rtl/adder6_if.sv | 38 +++
 rtl/cla4_group.sv | 54 +++++
 rtl/adder6.sv | 66 ++++++
 tb/tb_adder6.sv | 139 +++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Constants shared by the adder6 carry-lookahead adder and its group slices.
//   GROUP_W : number of bits resolved by one lookahead group
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int GROUP_W = 4;

endpackage : adder_pkg

// File: rtl/adder6_if.sv
// ----------------------------------------------------------------------------
// adder6_if
// Bundles the operand/result signals of the adder6 block.
//   A, B   : operands, unsigned, WIDTH bits (driven by master)
//   C0     : carry-in (driven by master)
//   F      : registered sum, WIDTH bits (driven by slave)
//   C4     : registered carry-out (driven by slave)
// Modports:
//   master : the side that supplies operands and consumes the result
//   slave  : the adder itself
// ----------------------------------------------------------------------------
interface adder6_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic [WIDTH-1:0] F;
    logic             C4;

    modport master (
        output A,
        output B,
        output C0,
        input  F,
        input  C4
    );

    modport slave (
        input  A,
        input  B,
        input  C0,
        output F,
        output C4
    );

endinterface : adder6_if

// File: rtl/cla4_group.sv
// ----------------------------------------------------------------------------
// cla4_group
// Purely combinational 4-bit carry-lookahead slice.
//   a, b : 4-bit operand slices
//   cin  : carry into bit 0 of the slice
//   s    : 4-bit sum slice
//   G    : group generate (slice produces a carry on its own)
//   P    : group propagate (slice passes cin straight through)
//   cout : carry out of the slice, G | P & cin
// Every internal carry is flattened to a two-level sum of products taken
// directly from cin, so no carry ripples through the slice.
// ----------------------------------------------------------------------------
module cla4_group
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               G,
    output logic               P,
    output logic               cout
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & cin);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign G = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

    assign w_c[4] = G | (P & cin);
    assign cout   = w_c[4];

    assign s = w_p ^ w_c[GROUP_W-1:0];

endmodule : cla4_group

// File: rtl/adder6.sv
// ----------------------------------------------------------------------------
// adder6
// Registered carry-lookahead adder: {C4, F} = A + B + C0, one cycle latency,
// one new result every cycle, no handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears F and C4
//   bus   : adder6_if slave modport (A, B, C0 in; F, C4 out)
// Parameter WIDTH must be a positive multiple of the lookahead group width.
// Groups are chained by their G/P pair; the group-local cout is redundant
// at this level and intentionally left unused.
// ----------------------------------------------------------------------------
module adder6
    import adder_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic     clk,
    input  logic     rst_n,
    adder6_if.slave  bus
);

    localparam int N_GRP = WIDTH / GROUP_W;

    if (WIDTH <= 0 || (WIDTH % GROUP_W) != 0) begin : g_bad_width
        $error("adder6: WIDTH (%0d) must be a positive multiple of %0d", WIDTH, GROUP_W);
    end

    logic [N_GRP:0]   w_carry;
    logic [N_GRP-1:0] w_grp_g;
    logic [N_GRP-1:0] w_grp_p;
    logic [N_GRP-1:0] w_unused_cout;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_f;
    logic             r_c4;

    assign w_carry[0] = bus.C0;

    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
        cla4_group u_grp (
            .a    (bus.A[gi*GROUP_W +: GROUP_W]),
            .b    (bus.B[gi*GROUP_W +: GROUP_W]),
            .cin  (w_carry[gi]),
            .s    (w_sum[gi*GROUP_W +: GROUP_W]),
            .G    (w_grp_g[gi]),
            .P    (w_grp_p[gi]),
            .cout (w_unused_cout[gi])
        );

        assign w_carry[gi+1] = w_grp_g[gi] | (w_grp_p[gi] & w_carry[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f  <= '0;
            r_c4 <= 1'b0;
        end else begin
            r_f  <= w_sum;
            r_c4 <= w_carry[N_GRP];
        end
    end

    assign bus.F  = r_f;
    assign bus.C4 = r_c4;

endmodule : adder6

// File: tb/tb_adder6.sv
// ----------------------------------------------------------------------------
// tb_adder6
// Self-checking bench for the 4-bit adder6 build. The reference is plain
// integer addition of the applied operands; results are expected one edge
// after capture, and the previous result must still be visible just before
// that edge.
// ----------------------------------------------------------------------------
module tb_adder6;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [4:0] exp_prev;

    adder6_if #(.WIDTH(4)) bus ();

    adder6 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] ref_sum(input int a, input int b, input int c);
        int total;
        total = a + b + c;
        return total[4:0];
    endfunction

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed C4/F=%b_%b expected C4/F=%b_%b",
                   tag, observed[4], observed[3:0], expected[4], expected[3:0]);
        end
    endtask

    // Drive one operand set, confirm the old result is still held before the
    // capturing edge, then confirm the new result right after it.
    task automatic apply(input int a, input int b, input int c, input string tag);
        logic [4:0] exp_now;
        logic [3:0] av;
        logic [3:0] bv;
        av = a[3:0];
        bv = b[3:0];
        bus.A  = av;
        bus.B  = bv;
        bus.C0 = c[0];
        #1;
        check({tag, "_hold"}, {bus.C4, bus.F}, exp_prev);
        @(posedge clk);
        #1;
        exp_now = ref_sum(a, b, c);
        check(tag, {bus.C4, bus.F}, exp_now);
        exp_prev = exp_now;
    endtask

    initial begin
        int idx;
        checks   = 0;
        errors   = 0;
        exp_prev = 5'd0;

        // Reset asserted with non-zero operands present
        rst_n  = 1'b0;
        bus.A  = 4'd9;
        bus.B  = 4'd9;
        bus.C0 = 1'b1;
        #2;
        check("reset_immediate", {bus.C4, bus.F}, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", {bus.C4, bus.F}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(9, 9, 1, "reset_release");

        // Zero / identity
        apply(0, 0, 0, "zero");
        apply(0, 0, 1, "zero_cin");

        // Boundaries
        apply(15, 1, 0, "wrap_15p1");
        apply(15, 15, 1, "max_31");
        apply(7, 8, 0, "mid_15");
        apply(7, 8, 1, "mid_wrap");

        // Full propagate chain, back-to-back
        apply(10, 5, 0, "prop_c0");
        apply(10, 5, 1, "prop_c1");

        // Exhaustive sweep with an asynchronous reset pulse part-way through
        idx = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    apply(a, b, c, "sweep");
                    if (idx == 300) begin
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check("async_reset_mid", {bus.C4, bus.F}, 5'd0);
                        @(posedge clk);
                        #1;
                        check("async_reset_edge", {bus.C4, bus.F}, 5'd0);
                        @(negedge clk);
                        rst_n    = 1'b1;
                        exp_prev = 5'd0;
                    end
                    idx++;
                end
            end
        end

        // Random back-to-back traffic
        for (int n = 0; n < 200; n++) begin
            apply(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                  int'($urandom_range(1, 0)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder6
